// File: rtl/flappy_pkg.sv
// Shared types and constants for the pipe/coin scroll game-flow control.
package flappy_pkg;

    localparam int SCORE_W = 8;
    localparam int LEVEL_W = 4;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

    // One-hot controller states
    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_ARM   = 6'b000010,
        ST_RUN   = 6'b000100,
        ST_HALT  = 6'b001000,
        ST_DONE  = 6'b010000,
        ST_CLEAR = 6'b100000
    } state_t;

endpackage

// File: rtl/step_divider.sv
// Scroll-step divider: counts clk cycles and emits a one-cycle step strobe
// every period_cur cycles. A requested period is latched only at a reload,
// so the period in progress always runs to completion.
module step_divider #(
    parameter int CNT_W        = 20,
    parameter int CLK_DIV_INIT = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period_req,
    output logic             step
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_cur;
    logic             reload;

    assign reload = en && (cnt == period_cur - CNT_W'(1));

    // Counter, period latch and registered step strobe; idle or cleared keeps the counter at 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            period_cur <= CNT_W'(CLK_DIV_INIT);
            step       <= 1'b0;
        end else if (clr || !en) begin
            cnt        <= '0;
            period_cur <= period_req;
            step       <= 1'b0;
        end else if (reload) begin
            cnt        <= '0;
            period_cur <= period_req;
            step       <= 1'b1;
        end else begin
            cnt        <= cnt + CNT_W'(1);
            step       <= 1'b0;
        end
    end

endmodule

// File: rtl/scroll_scheduler.sv
// Game-flow controller: sequences the datapath Start/Stop/Ack handshake,
// keeps score and speed level, and paces scrolling through step_divider.
module scroll_scheduler
    import flappy_pkg::*;
#(
    parameter int CLK_DIV_INIT = 500000,
    parameter int DIV_STEP     = 50000,
    parameter int DIV_MIN      = 150000,
    parameter int LEVEL_PIPES  = 8,
    parameter int CNT_W        = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               collision,
    input  logic               pipe_passed,
    input  logic               dp_q_initial,
    input  logic               dp_q_count,
    input  logic               dp_q_stop,
    output logic               start,
    output logic               stop,
    output logic               ack,
    output logic               step,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic               game_over,
    output logic               busy
);

    localparam int PASS_W = $clog2(LEVEL_PIPES + 1);
    localparam int PW     = CNT_W + 4;

    state_t             state;
    logic [PASS_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]   period_req;
    logic               fb_initial;
    logic               fb_count;
    logic               fb_stop;
    logic               div_en;
    logic               div_clr;

    // Step period for a level: CLK_DIV_INIT - level*DIV_STEP, clamped at DIV_MIN,
    // where a wrap-around (subtrahend larger than CLK_DIV_INIT) also clamps.
    function automatic logic [CNT_W-1:0] period_for(input logic [LEVEL_W-1:0] lv);
        logic [PW-1:0] dec;
        logic [PW-1:0] base;
        logic [PW-1:0] diff;
        dec  = PW'(lv) * PW'(DIV_STEP);
        base = PW'(CLK_DIV_INIT);
        diff = base - dec;
        if ((dec > base) || (diff < PW'(DIV_MIN)))
            return CNT_W'(DIV_MIN);
        return diff[CNT_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

    function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] l);
        return (l == LEVEL_MAX) ? l : l + LEVEL_W'(1);
    endfunction

    // Datapath feedback only acknowledges when exactly one state bit is high
    assign fb_initial = dp_q_initial & ~dp_q_count   & ~dp_q_stop;
    assign fb_count   = dp_q_count   & ~dp_q_initial & ~dp_q_stop;
    assign fb_stop    = dp_q_stop    & ~dp_q_initial & ~dp_q_count;

    // Steps run in RUN and HALT; reaching DONE clears the divider on the same edge
    assign div_en  = (state == ST_RUN) || (state == ST_HALT);
    assign div_clr = (state == ST_HALT) && fb_stop;

    // Controller FSM with registered handshake/status outputs, score and level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            start      <= 1'b0;
            stop       <= 1'b0;
            ack        <= 1'b0;
            game_over  <= 1'b0;
            busy       <= 1'b0;
            score      <= '0;
            level      <= '0;
            pass_cnt   <= '0;
            period_req <= CNT_W'(CLK_DIV_INIT);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_start) begin
                        state      <= ST_ARM;
                        start      <= 1'b1;
                        busy       <= 1'b1;
                        score      <= '0;
                        level      <= '0;
                        pass_cnt   <= '0;
                        period_req <= period_for('0);
                    end
                end
                ST_ARM: begin
                    if (fb_count) begin
                        state <= ST_RUN;
                        start <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (collision) begin
                        state <= ST_HALT;
                        stop  <= 1'b1;
                    end else if (pipe_passed) begin
                        score <= score_inc(score);
                        if (pass_cnt == PASS_W'(LEVEL_PIPES - 1)) begin
                            pass_cnt   <= '0;
                            level      <= level_inc(level);
                            period_req <= period_for(level_inc(level));
                        end else begin
                            pass_cnt <= pass_cnt + PASS_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (fb_stop) begin
                        state     <= ST_DONE;
                        stop      <= 1'b0;
                        game_over <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (btn_start) begin
                        state     <= ST_CLEAR;
                        game_over <= 1'b0;
                        ack       <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (fb_initial) begin
                        state <= ST_IDLE;
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    start     <= 1'b0;
                    stop      <= 1'b0;
                    ack       <= 1'b0;
                    game_over <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    step_divider #(
        .CNT_W        (CNT_W),
        .CLK_DIV_INIT (CLK_DIV_INIT)
    ) u_step_divider (
        .clk        (clk),
        .reset      (reset),
        .en         (div_en),
        .clr        (div_clr),
        .period_req (period_req),
        .step       (step)
    );

endmodule

// File: tb/tb_scroll_scheduler.sv
// Bench for scroll_scheduler: directed game scenarios plus a randomized
// phase, all checked against a time-based behavioural model.
module tb_scroll_scheduler;

    localparam int CLK_DIV_INIT = 10;
    localparam int DIV_STEP     = 2;
    localparam int DIV_MIN      = 4;
    localparam int LEVEL_PIPES  = 2;
    localparam int CNT_W        = 8;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       btn_start    = 1'b0;
    logic       collision    = 1'b0;
    logic       pipe_passed  = 1'b0;
    logic       dp_q_initial = 1'b0;
    logic       dp_q_count   = 1'b0;
    logic       dp_q_stop    = 1'b0;
    logic       start, stop, ack, step, game_over, busy;
    logic [7:0] score;
    logic [3:0] level;

    int checks   = 0;
    int failures = 0;
    int pcyc     = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    scroll_scheduler #(
        .CLK_DIV_INIT (CLK_DIV_INIT),
        .DIV_STEP     (DIV_STEP),
        .DIV_MIN      (DIV_MIN),
        .LEVEL_PIPES  (LEVEL_PIPES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_start    (btn_start),
        .collision    (collision),
        .pipe_passed  (pipe_passed),
        .dp_q_initial (dp_q_initial),
        .dp_q_count   (dp_q_count),
        .dp_q_stop    (dp_q_stop),
        .start        (start),
        .stop         (stop),
        .ack          (ack),
        .step         (step),
        .score        (score),
        .level        (level),
        .game_over    (game_over),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_ARM, M_RUN, M_HALT, M_DONE, M_CLEAR} mstate_t;

    mstate_t ms      = M_IDLE;
    int      m_score = 0;
    int      m_level = 0;
    int      m_pass  = 0;
    int      m_cyc   = 0;
    int      m_next  = 0;
    bit      m_step  = 1'b0;

    function automatic int period_of(input int lv);
        int p;
        p = CLK_DIV_INIT - lv * DIV_STEP;
        return (p < DIV_MIN) ? DIV_MIN : p;
    endfunction

    // Model: steps fall at absolute cycle times; each step picks the next period from the level
    always @(posedge clk or negedge reset) begin : model
        mstate_t s;
        int      sc, lv, ps, c, nxt;
        bit      stp, oh;
        if (!reset) begin
            ms <= M_IDLE; m_score <= 0; m_level <= 0; m_pass <= 0;
            m_cyc <= 0; m_next <= 0; m_step <= 1'b0;
        end else begin
            s = ms; sc = m_score; lv = m_level; ps = m_pass; nxt = m_next;
            c = m_cyc + 1; stp = 1'b0;
            oh = ($countones({dp_q_initial, dp_q_count, dp_q_stop}) == 1);
            if ((s == M_RUN || s == M_HALT) && c == nxt && !(s == M_HALT && oh && dp_q_stop)) begin
                stp = 1'b1;
                nxt = c + period_of(lv);
            end
            case (s)
                M_IDLE:  if (btn_start) begin s = M_ARM; sc = 0; lv = 0; ps = 0; end
                M_ARM:   if (oh && dp_q_count) begin s = M_RUN; nxt = c + period_of(lv); end
                M_RUN: begin
                    if (collision) s = M_HALT;
                    else if (pipe_passed) begin
                        if (sc < 255) sc++;
                        ps++;
                        if (ps == LEVEL_PIPES) begin
                            ps = 0;
                            if (lv < 15) lv++;
                        end
                    end
                end
                M_HALT:  if (oh && dp_q_stop) s = M_DONE;
                M_DONE:  if (btn_start) s = M_CLEAR;
                M_CLEAR: if (oh && dp_q_initial) s = M_IDLE;
                default: s = M_IDLE;
            endcase
            ms <= s; m_score <= sc; m_level <= lv; m_pass <= ps;
            m_next <= nxt; m_cyc <= c; m_step <= stp;
        end
    end

    // Cycle stamp for measuring step spacing
    always @(posedge clk) pcyc <= pcyc + 1;

    // Every cycle, compare all outputs against the model
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("start",     start,     ms == M_ARM);
            check_eq("stop",      stop,      ms == M_HALT);
            check_eq("ack",       ack,       ms == M_CLEAR);
            check_eq("game_over", game_over, ms == M_DONE);
            check_eq("busy",      busy,      ms != M_IDLE);
            check_eq("step",      step,      m_step);
            check_eq("score",     score,     m_score);
            check_eq("level",     level,     m_level);
            check_eq("hs_excl",   $countones({start, stop, ack}) <= 1, 1);
        end
    end

    task automatic wait_step(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                t = pcyc;
                break;
            end
        end
        if (t < 0) check_eq("step_wait", step, 1'b1);
    endtask

    task automatic pulse_pass();
        @(negedge clk); pipe_passed = 1'b1;
        @(negedge clk); pipe_passed = 1'b0;
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0, t1, t2, t3, n, r;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  busy,  0);
        check_eq("rst_start", start, 0);
        check_eq("rst_step",  step,  0);
        check_eq("rst_score", score, 0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Start handshake: dp_q_count arrives after three ARM cycles
        @(negedge clk); btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0; n = int'(start);
        @(negedge clk); n += int'(start);
        @(negedge clk); n += int'(start); dp_q_count = 1'b1;
        check_eq("arm_start_cycles", n, 3);
        @(negedge clk); t0 = pcyc;
        check_eq("run_start_low", start, 0);
        wait_step(t1);
        check_eq("first_step_gap", t1 - t0, 10);

        // Level 1 after two passes; period in progress still 10, then 8
        pipe_passed = 1'b1;
        @(negedge clk); pipe_passed = 1'b0;
        @(negedge clk); pipe_passed = 1'b1;
        @(negedge clk); pipe_passed = 1'b0;
        wait_step(t2);
        check_eq("gap_in_progress", t2 - t1, 10);
        check_eq("score_2", score, 2);
        check_eq("level_1", level, 1);
        wait_step(t3);
        check_eq("gap_level1", t3 - t2, 8);

        // Eight more passes: level 5, period reaches the floor
        repeat (8) pulse_pass();
        check_eq("score_10", score, 10);
        check_eq("level_5", level, 5);
        wait_step(t1); wait_step(t2); wait_step(t3);
        check_eq("gap_floor", t3 - t2, 4);
        repeat (4) pulse_pass();
        check_eq("level_7", level, 7);
        wait_step(t1); wait_step(t2); wait_step(t3);
        check_eq("gap_underflow", t3 - t2, 4);

        // Asynchronous reset in the middle of a game
        @(posedge clk); #2 reset = 1'b0;
        #1;
        check_eq("arst_outs", {start, stop, ack, step, game_over, busy}, 0);
        check_eq("arst_score", score, 0);
        check_eq("arst_level", level, 0);
        @(negedge clk); reset = 1'b1; dp_q_count = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);

        // Collision held in ARM and btn_start in ARM/RUN are ignored
        @(negedge clk); btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0; collision = 1'b1;
        @(negedge clk); btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0;
        check_eq("arm_no_stop", stop, 0);
        check_eq("arm_start", start, 1);
        dp_q_count = 1'b1;
        @(negedge clk); collision = 1'b0;
        check_eq("run_entered", start, 0);
        @(negedge clk); btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0;
        check_eq("run_btn_no_stop", stop, 0);
        repeat (3) pulse_pass();
        check_eq("score_3", score, 3);

        // Collision and pass together: pass dropped, steps continue in HALT
        @(negedge clk); collision = 1'b1; pipe_passed = 1'b1;
        @(negedge clk); pipe_passed = 1'b0;
        check_eq("halt_stop", stop, 1);
        check_eq("halt_score", score, 3);
        wait_step(t1); wait_step(t2);
        dp_q_count = 1'b0; dp_q_stop = 1'b1;
        @(negedge clk); dp_q_stop = 1'b0; collision = 1'b0;
        check_eq("done_game_over", game_over, 1);
        n = 0;
        repeat (30) begin @(negedge clk); n += int'(step); end
        check_eq("done_no_step", n, 0);

        // Clear handshake, ambiguous feedback first, then back to IDLE
        btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0;
        check_eq("clear_ack", ack, 1);
        dp_q_initial = 1'b1; dp_q_stop = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("clear_ambig_ack", ack, 1);
        dp_q_stop = 1'b0;
        @(negedge clk); dp_q_initial = 1'b0;
        check_eq("idle_ack", ack, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_score_held", score, 3);
        btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0;
        check_eq("restart_start", start, 1);
        check_eq("restart_score", score, 0);
        check_eq("restart_level", level, 0);

        // Saturation run
        dp_q_count = 1'b1;
        repeat (300) pulse_pass();
        check_eq("score_sat", score, 255);
        check_eq("level_sat", level, 15);

        // Randomized play driven by the model's view of the game state
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            btn_start = 1'b0; collision = 1'b0; pipe_passed = 1'b0;
            dp_q_initial = 1'b0; dp_q_count = 1'b0; dp_q_stop = 1'b0;
            r = int'($urandom_range(0, 15));
            case (ms)
                M_IDLE: begin
                    btn_start    = ($urandom_range(0, 5) == 0);
                    dp_q_initial = 1'($urandom_range(0, 1));
                end
                M_ARM: begin
                    collision = 1'($urandom_range(0, 1));
                    btn_start = ($urandom_range(0, 7) == 0);
                    if (r < 4) dp_q_count = 1'b1;
                    else if (r == 4) begin dp_q_count = 1'b1; dp_q_stop = 1'b1; end
                    else if (r == 5) begin dp_q_count = 1'b1; dp_q_initial = 1'b1; end
                end
                M_RUN: begin
                    dp_q_count  = 1'b1;
                    pipe_passed = ($urandom_range(0, 2) == 0);
                    btn_start   = ($urandom_range(0, 15) == 0);
                    collision   = ($urandom_range(0, 79) == 0);
                end
                M_HALT: begin
                    collision   = 1'($urandom_range(0, 1));
                    pipe_passed = 1'($urandom_range(0, 1));
                    btn_start   = ($urandom_range(0, 7) == 0);
                    if (r == 0) dp_q_stop = 1'b1;
                    else if (r == 1) begin dp_q_stop = 1'b1; dp_q_count = 1'b1; end
                    else dp_q_count = 1'b1;
                end
                M_DONE: begin
                    dp_q_stop = 1'b1;
                    btn_start = ($urandom_range(0, 9) == 0);
                end
                default: begin
                    btn_start = ($urandom_range(0, 5) == 0);
                    if (r < 3) dp_q_initial = 1'b1;
                    else if (r == 3) begin dp_q_initial = 1'b1; dp_q_stop = 1'b1; end
                end
            endcase
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
